// File: rtl/codma_bus_pkg.sv
// Shared bus definitions for the CoDMA memory slave: size codes, slave FSM states and
// helpers converting a size code into a beat count and a byte count.
package codma_bus_pkg;

   localparam logic [3:0] SZ_B       = 4'd0;
   localparam logic [3:0] SZ_H       = 4'd1;
   localparam logic [3:0] SZ_W       = 4'd2;
   localparam logic [3:0] SZ_DW      = 4'd3;
   localparam logic [3:0] SZ_BURST2  = 4'd8;
   localparam logic [3:0] SZ_BURST4  = 4'd9;
   localparam logic [3:0] SZ_BURST8  = 4'd10;
   localparam logic [3:0] SZ_BURST16 = 4'd11;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StGrant,
      StRd,
      StWr,
      StErr
   } slv_state_e;

   function automatic logic [31:0] size_to_beats(input logic [3:0] size);
      if (size >= SZ_BURST2) begin
         return 32'd1 << (size - 4'd7);
      end
      return 32'd1;
   endfunction

   // Single-beat codes move 2**size bytes; burst codes move whole words.
   function automatic logic [31:0] size_to_bytes(input logic [3:0] size,
                                                 input int unsigned bytes);
      if (size >= SZ_BURST2) begin
         return size_to_beats(size) * bytes;
      end
      return 32'd1 << size;
   endfunction

endpackage

// File: rtl/mem_be_array.sv
// Word storage with per-byte write enables and a registered read port whose one-cycle
// latency lines up with the slave's read_valid_o.
module mem_be_array #(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned MEM_DEPTH = 32,
   parameter int unsigned AW        = 5
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  we_i,
   input  logic [DATA_W/8-1:0]   be_i,
   input  logic [AW-1:0]         addr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic                  re_i,
   output logic [DATA_W-1:0]     rdata_o
);

   localparam int unsigned BYTES = DATA_W / 8;

   logic [DATA_W-1:0] mem_q [MEM_DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Contents deliberately survive reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int unsigned b = 0; b < BYTES; b++) begin
            if (be_i[b]) begin
               mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ip_mem_burst_slave.sv
// Parametrised bus memory slave: captures one request, checks range/alignment, then
// grants and either rejects it or streams read/write beats against mem_be_array.
module ip_mem_burst_slave
   import codma_bus_pkg::*;
#(
   parameter int unsigned MEM_DEPTH      = 32,
   parameter int unsigned DATA_W         = 64,
   parameter int unsigned BASE_ADDR      = 0,
   parameter int unsigned GRANT_LAT      = 0,
   parameter int unsigned READ_GAP       = 0,
   parameter int unsigned MAX_BURST_LOG2 = 3
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              read_i,
   input  logic              write_i,
   input  logic [31:0]       addr_i,
   input  logic [3:0]        size_i,
   output logic              grant_o,
   input  logic [DATA_W-1:0] write_data_i,
   input  logic              write_valid_i,
   output logic [DATA_W-1:0] read_data_o,
   output logic              read_valid_o,
   output logic              error_o,
   output logic              busy_o
);

   localparam int unsigned BYTES   = DATA_W / 8;
   localparam int unsigned LB      = $clog2(BYTES);
   localparam int unsigned AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned CW      = MAX_BURST_LOG2 + 1;
   localparam logic [32:0] MEM_END = 33'(BASE_ADDR) + 33'(MEM_DEPTH * BYTES);
   localparam logic [3:0]  SZ_MAX  = 4'(7 + MAX_BURST_LOG2);

   slv_state_e      state_q, state_d;
   logic            rd_q, rd_d;
   logic [31:0]     addr_q, addr_d;
   logic [3:0]      size_q, size_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      gap_q, gap_d;
   logic [3:0]      wait_q, wait_d;
   logic            rvalid_q;

   logic            is_burst, bad_size, err, re, we;
   logic [31:0]     nbytes, rel;
   logic [32:0]     last_byte;
   logic [CW-1:0]   total;
   logic [AW-1:0]   base_idx, mem_idx;
   logic [BYTES-1:0] be;

   // Request checks run on the captured copy so they have a full cycle before grant.
   always_comb begin
      is_burst  = size_q >= SZ_BURST2;
      nbytes    = size_to_bytes(size_q, BYTES);
      total     = CW'(size_to_beats(size_q));
      last_byte = {1'b0, addr_q} + {1'b0, nbytes} - 33'd1;
      bad_size  = ((size_q > SZ_DW) && (size_q < SZ_BURST2)) || (size_q > SZ_MAX);
      err       = bad_size || (addr_q < BASE_ADDR) || (last_byte >= MEM_END) ||
                  (is_burst ? (addr_q[LB-1:0] != '0)
                            : (((addr_q & (nbytes - 32'd1)) != '0) || (nbytes > BYTES)));
      rel       = addr_q - BASE_ADDR;
      base_idx  = AW'(rel >> LB);
      mem_idx   = base_idx + AW'(cnt_q);
      be        = '0;
      for (int unsigned b = 0; b < BYTES; b++) begin
         be[b] = is_burst || ((b >= 32'(addr_q[LB-1:0])) &&
                              (b < 32'(addr_q[LB-1:0]) + nbytes));
      end
   end

   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      size_d  = size_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      wait_d  = wait_q;
      grant_o = 1'b0;
      error_o = 1'b0;
      re      = 1'b0;
      we      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (read_i || write_i) begin
               rd_d    = read_i;
               addr_d  = addr_i;
               size_d  = size_i;
               cnt_d   = '0;
               wait_d  = 4'(GRANT_LAT);
               state_d = (GRANT_LAT == 0) ? StGrant : StWait;
            end
         end
         StWait: begin
            wait_d = wait_q - 4'd1;
            if (wait_q == 4'd1) state_d = StGrant;
         end
         StGrant: begin
            grant_o = 1'b1;
            if (err) begin
               state_d = StErr;
            end else if (rd_q) begin
               re      = 1'b1;
               cnt_d   = CW'(1);
               gap_d   = 4'(READ_GAP);
               state_d = StRd;
            end else begin
               state_d = StWr;
            end
         end
         StRd: begin
            // cnt_q counts beats already issued to the array.
            if (rvalid_q && (cnt_q == total)) begin
               state_d = StIdle;
            end else if (cnt_q != total) begin
               if (gap_q != 4'd0) begin
                  gap_d = gap_q - 4'd1;
               end else begin
                  re    = 1'b1;
                  cnt_d = cnt_q + CW'(1);
                  gap_d = 4'(READ_GAP);
               end
            end
         end
         StWr: begin
            if (write_valid_i) begin
               we    = 1'b1;
               cnt_d = cnt_q + CW'(1);
               if (cnt_d == total) state_d = StIdle;
            end
         end
         StErr: begin
            error_o = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= StIdle;
         rd_q     <= 1'b0;
         addr_q   <= '0;
         size_q   <= '0;
         cnt_q    <= '0;
         gap_q    <= '0;
         wait_q   <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rd_q     <= rd_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         cnt_q    <= cnt_d;
         gap_q    <= gap_d;
         wait_q   <= wait_d;
         rvalid_q <= re;
      end
   end

   assign read_valid_o = rvalid_q;
   assign busy_o       = (state_q != StIdle);

   mem_be_array #(
      .DATA_W    (DATA_W),
      .MEM_DEPTH (MEM_DEPTH),
      .AW        (AW)
   ) u_mem (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .we_i    (we),
      .be_i    (be),
      .addr_i  (mem_idx),
      .wdata_i (write_data_i),
      .re_i    (re),
      .rdata_o (read_data_o)
   );

endmodule
